// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout set when it borrows.
// Purely combinational; no handshake.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first; WIDTH+1 cycles from accept to out_valid.
// Holds the result in DONE until out_ready; in_ready only in IDLE.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   d_q;

  logic             cell_diff;
  logic             cell_bout;
  logic [WIDTH-1:0] diff_word_d;
  logic             run_step;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign run_step = (state_q == RUN);

  // Earlier difference bits sit below the one the cell is producing now;
  // the oldest bit has been shifted all the way down to the LSB.
  if (WIDTH > 1) begin : g_res
    logic [WIDTH-2:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q <= '0;
      end else if (run_step) begin
        res_q <= diff_word_d[WIDTH-1:1];
      end
    end

    assign diff_word_d = {cell_diff, res_q};
  end else begin : g_res1
    assign diff_word_d = cell_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= cell_bout;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            d_q     <= {cell_bout, diff_word_d};
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] d;

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y, input logic z);
    logic [4:0] r;
    r = {1'b0, x} - {1'b0, y} - {4'd0, z};
    return r;
  endfunction

  // Presents one operation at a negedge in IDLE and waits for out_valid.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                        input logic [4:0] exp, input string tag);
    bit ok;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, {31'd0, ok}, 32'd1);
    if (ok) chk({tag, "_d"}, {27'd0, d}, {27'd0, exp});
  endtask

  initial begin
    bit done;
    logic [4:0] exp;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {27'd0, d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 9 - 3 with exact latency: accept in T, out_valid only in T+5
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_t1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("lat_t1_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("lat_t4_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_t5_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_9_3", {27'd0, d}, 32'h06);
    @(negedge clk);
    chk("lat_t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_t6_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(4'd3, 4'd9, 1'b0, 5'b1_1010, "sub_3_9");
    run_op(4'd0, 4'd0, 1'b1, 5'b1_1111, "sub_0_0_b1");

    // 15 - 15 held in DONE by out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    run_op(4'd15, 4'd15, 1'b0, 5'b0_0000, "sub_15_15");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_d", {27'd0, d}, 32'h00);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);

    // 7 - 2 with inputs toggling during RUN, then back-to-back 2 - 7
    a = 4'd7; b = 4'd2; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd14; in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    a = 4'd2; b = 4'd7; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("tog_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_7_2", {27'd0, d}, 32'h05);
    chk("tog_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_in_ready_t6", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepted", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("b2b_t10_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_t11_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_2_7", {27'd0, d}, 32'h1B);

    // Asynchronous reset two bits into RUN
    @(negedge clk);
    a = 4'd10; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_d", {27'd0, d}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd12, 4'd5, 1'b0, 5'b0_0111, "sub_12_5");

    // Exhaustive sweep with random stalls on both handshakes
    @(negedge clk);
    out_ready = 1'b0;
    for (int v = 0; v < 512; v++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = v[8:5]; b = v[4:1]; bin = v[0];
      exp = ref_sub(v[8:5], v[4:1], v[0]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (out_valid) begin
          chk("sweep_d", {27'd0, d}, {27'd0, exp});
          out_ready = 1'($urandom_range(0, 1));
          if (out_ready) done = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      chk("sweep_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      if (!in_ready) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
